// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: minuend - subtrahend, one bit per clock,
// LSB first, through one full-subtractor cell and a registered borrow flop.
//
// Handshake: an operation is accepted on any rising edge where i_start=1 and
// the block is not in RUN (i.e. IDLE or DONE); o_busy is high for exactly the
// WIDTH cycles of RUN, o_done pulses for the single DONE cycle that follows,
// and o_bit/o_bit_valid carry the difference bit the cell produces in each
// RUN cycle (the bit that is registered on that cycle's closing edge).
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_minuend,
    input  logic [WIDTH-1:0] i_subtrahend,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow,
    output logic             o_bit,
    output logic             o_bit_valid,
    output logic [1:0]       o_state
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic [CW-1:0]    count;
    logic             borrow;
    logic             borrow_next;
    logic             d;
    logic             last;
    logic             load;
    logic             bit_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;

    // Full-subtractor cell on the current LSBs plus the new result word.
    always_comb begin
        d           = a_sr[0] ^ b_sr[0] ^ borrow;
        borrow_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow);
        res_next    = {d, res_sr[WIDTH-1:1]};
        last        = (count == LAST);
        load        = i_start && (state != RUN);
    end

    // Next-state logic; DONE may chain straight into a new RUN.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_start) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    state_next = i_start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_next;
    end

    // Operand capture, per-bit shifting and result/borrow latching on the last bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            borrow   <= 1'b0;
            count    <= '0;
            bit_q    <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else if (load) begin
            a_sr   <= i_minuend;
            b_sr   <= i_subtrahend;
            res_sr <= '0;
            borrow <= 1'b0;
            count  <= '0;
        end else if (state == RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= res_next;
            borrow <= borrow_next;
            bit_q  <= d;
            count  <= last ? '0 : count + 1'b1;
            if (last) begin
                diff_q   <= res_next;
                borrow_q <= borrow_next;
            end
        end
    end

    // Outputs: status decoded from state; o_bit holds the last bit outside RUN.
    always_comb begin
        o_busy      = (state == RUN);
        o_done      = (state == DONE);
        o_bit_valid = (state == RUN);
        o_bit       = (state == RUN) ? d : bit_q;
        o_diff      = diff_q;
        o_borrow    = borrow_q;
        o_state     = state;
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8). Inputs are driven on the
// falling edge, outputs sampled on the falling edge.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] minuend;
    logic [W-1:0] subtrahend;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
    logic         bit_out;
    logic         bit_valid;
    logic [1:0]   state;

    int tests_run;
    int tests_failed;

    logic [W:0] exp_q[$];

    serial_subtractor #(.WIDTH(W)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_minuend    (minuend),
        .i_subtrahend (subtrahend),
        .o_busy       (busy),
        .o_done       (done),
        .o_diff       (diff),
        .o_borrow     (borrow),
        .o_bit        (bit_out),
        .o_bit_valid  (bit_valid),
        .o_state      (state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Put operands on the bus with i_start high; the next rising edge accepts them.
    task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W:0] exp_word);
        start      = 1'b1;
        minuend    = a;
        subtrahend = b;
        exp_q.push_back(exp_word);
    endtask

    // Walk the W RUN cycles checking the serial stream, then the DONE cycle.
    // repulse: re-raise start with 9/3 in RUN cycle 3 (must be ignored).
    // chain: in the DONE cycle, start 9-3 back-to-back.
    task automatic run_op(input string tag, input bit repulse, input bit chain);
        logic [W:0] exp_word;
        exp_word = exp_q[0];
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            check({tag, " busy"}, 32'(busy), 32'd1);
            check({tag, " bit_valid"}, 32'(bit_valid), 32'd1);
            check({tag, " done_low"}, 32'(done), 32'd0);
            check({tag, $sformatf(" bit%0d", i)}, 32'(bit_out), 32'(exp_word[i]));
            if (repulse && i == 2) begin
                start = 1'b1; minuend = 8'd9; subtrahend = 8'd3;
            end
            if (repulse && i == 3) start = 1'b0;
        end
        @(negedge clk);
        exp_word = exp_q.pop_front();
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " busy_done"}, 32'(busy), 32'd0);
        check({tag, " bit_valid_done"}, 32'(bit_valid), 32'd0);
        check({tag, " bit_hold"}, 32'(bit_out), 32'(exp_word[W-1]));
        check({tag, " diff"}, 32'(diff), 32'(exp_word[W-1:0]));
        check({tag, " borrow"}, 32'(borrow), 32'(exp_word[W]));
        if (chain) drive_start(8'd9, 8'd3, {1'b0, 8'd6});
    endtask

    task automatic expect_idle(input string tag, input logic [W:0] held);
        @(negedge clk);
        check({tag, " idle_done"}, 32'(done), 32'd0);
        check({tag, " idle_busy"}, 32'(busy), 32'd0);
        check({tag, " idle_state"}, 32'(state), 32'd0);
        check({tag, " diff_held"}, 32'(diff), 32'(held[W-1:0]));
        check({tag, " borrow_held"}, 32'(borrow), 32'(held[W]));
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        start = 1'b0;
        minuend = '0;
        subtrahend = '0;
        repeat (2) @(negedge clk);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst diff", 32'(diff), 32'd0);
        check("rst borrow", 32'(borrow), 32'd0);
        check("rst bit", 32'(bit_out), 32'd0);
        check("rst bit_valid", 32'(bit_valid), 32'd0);
        check("rst state", 32'(state), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 200 - 55 = 145 (0x91), no borrow; stream 1,0,0,0,1,0,0,1
        drive_start(8'd200, 8'd55, {1'b0, 8'h91});
        run_op("t1", 1'b0, 1'b0);
        expect_idle("t1", {1'b0, 8'h91});

        // 55 - 200 = 111 (0x6F), borrow
        drive_start(8'd55, 8'd200, {1'b1, 8'h6F});
        run_op("t2", 1'b0, 1'b0);
        expect_idle("t2", {1'b1, 8'h6F});

        // 0 - 1 = 0xFF, borrow ripples the full width
        drive_start(8'h00, 8'h01, {1'b1, 8'hFF});
        run_op("t3", 1'b0, 1'b0);
        expect_idle("t3", {1'b1, 8'hFF});

        // 0xA5 - 0xA5 = 0, start re-pulse mid-run ignored, then chained 9 - 3 = 6
        drive_start(8'hA5, 8'hA5, {1'b0, 8'h00});
        run_op("t4", 1'b1, 1'b1);
        run_op("t4b", 1'b0, 1'b0);
        expect_idle("t4b", {1'b0, 8'h06});

        // Reset after 4 bits of 200 - 55: asynchronous clear, no done
        drive_start(8'd200, 8'd55, {1'b0, 8'h91});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        check("t5 rst busy", 32'(busy), 32'd0);
        check("t5 rst done", 32'(done), 32'd0);
        check("t5 rst diff", 32'(diff), 32'd0);
        check("t5 rst borrow", 32'(borrow), 32'd0);
        check("t5 rst bit", 32'(bit_out), 32'd0);
        check("t5 rst bit_valid", 32'(bit_valid), 32'd0);
        void'(exp_q.pop_front());
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk);
            check("t5 no_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // 10 - 20 = 246, borrow
        drive_start(8'd10, 8'd20, {1'b1, 8'd246});
        run_op("t6", 1'b0, 1'b0);
        expect_idle("t6", {1'b1, 8'd246});

        check("queue empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
